// File: rtl/dfe_stage_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : dfe_stage_monitor
//  Description : Per-stage tap monitor for a DFE chain. Provides a registered
//                tap, sticky flags, a sample counter and a snapshot buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfe_stage_monitor #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_STAGES = 6,
    parameter int CAP_DEPTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic signed [NUM_STAGES-1:0][DATA_WIDTH-1:0]  stage_data,
    input  logic        [NUM_STAGES-1:0]                  stage_valid,
    input  logic        [NUM_STAGES-1:0]                  stage_ovf,
    input  logic        [NUM_STAGES-1:0]                  stage_unf,
    input  logic        [$clog2(NUM_STAGES)-1:0]          cfg_sel,
    input  logic                                          arm,
    input  logic                                          sticky_clr,
    input  logic                                          rd_en,
    output logic signed [DATA_WIDTH-1:0]                  mon_out,
    output logic                                          mon_valid,
    output logic        [NUM_STAGES-1:0]                  sticky_ovf,
    output logic        [NUM_STAGES-1:0]                  sticky_unf,
    output logic        [CNT_WIDTH-1:0]                   sample_cnt,
    output logic                                          cap_busy,
    output logic                                          cap_done,
    output logic signed [DATA_WIDTH-1:0]                  rd_data,
    output logic                                          rd_valid
);

    localparam int c_SEL_W = $clog2(NUM_STAGES);
    localparam int c_PTR_W = $clog2(CAP_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(CAP_DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    logic                  w_sel_ok;
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_chg;
    logic                  w_wr_en;
    logic                  w_ptr_clr;
    logic                  w_rd_fire;
    logic [1:0]            w_state_nxt;

    logic [1:0]            r_state;
    logic [c_SEL_W-1:0]    r_sel_prev;
    logic [DATA_WIDTH-1:0] r_mon_out;
    logic                  r_mon_valid;
    logic [NUM_STAGES-1:0] r_sticky_ovf;
    logic [NUM_STAGES-1:0] r_sticky_unf;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_mem [CAP_DEPTH];

    // Explicit compare loop keeps out-of-range selects from indexing the bus.
    always_comb begin
        w_sel_ok    = 1'b0;
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (cfg_sel == c_SEL_W'(i)) begin
                w_sel_ok    = 1'b1;
                w_sel_valid = stage_valid[i];
                w_sel_data  = stage_data[i];
            end
        end
    end

    assign w_sel_chg = (cfg_sel != r_sel_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_prev   <= '0;
            r_mon_out    <= '0;
            r_mon_valid  <= 1'b0;
            r_sticky_ovf <= '0;
            r_sticky_unf <= '0;
            r_cnt        <= '0;
        end else begin
            r_sel_prev   <= cfg_sel;
            r_mon_valid  <= w_sel_valid;
            if (!w_sel_ok) begin
                r_mon_out <= '0;
            end else if (w_sel_valid) begin
                r_mon_out <= w_sel_data;
            end
            // A flag arriving alongside the clear must survive it.
            r_sticky_ovf <= (r_sticky_ovf & ~{NUM_STAGES{sticky_clr}}) | stage_ovf;
            r_sticky_unf <= (r_sticky_unf & ~{NUM_STAGES{sticky_clr}}) | stage_unf;
            if (w_sel_chg) begin
                r_cnt <= '0;
            end else if (w_sel_valid && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (arm) w_state_nxt = c_ST_CAPTURE;
            end
            c_ST_CAPTURE: begin
                if (w_sel_chg) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_sel_valid && (r_wr_ptr == c_LAST)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (arm) w_state_nxt = c_ST_CAPTURE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        cap_busy  = (r_state == c_ST_CAPTURE);
        cap_done  = (r_state == c_ST_DONE);
        w_wr_en   = (r_state == c_ST_CAPTURE) && w_sel_valid && !w_sel_chg;
        w_ptr_clr = (r_state != c_ST_CAPTURE) && arm;
        w_rd_fire = (r_state == c_ST_DONE) && rd_en && !arm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_ptr_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_rd_fire) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                    r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    // Buffer storage carries no reset; it is only readable after a full capture.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_sel_data;
    end

    assign mon_out    = r_mon_out;
    assign mon_valid  = r_mon_valid;
    assign sticky_ovf = r_sticky_ovf;
    assign sticky_unf = r_sticky_unf;
    assign sample_cnt = r_cnt;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_dfe_stage_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dfe_stage_monitor
//  Description : Self-checking bench for dfe_stage_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfe_stage_monitor;

    localparam int DW = 16;
    localparam int NS = 6;
    localparam int CD = 32;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NS-1:0][DW-1:0] stage_data;
    logic [NS-1:0]        stage_valid, stage_ovf, stage_unf;
    logic [2:0]           cfg_sel;
    logic                 arm, sticky_clr, rd_en;
    logic [DW-1:0]        mon_out, rd_data;
    logic                 mon_valid, rd_valid, cap_busy, cap_done;
    logic [NS-1:0]        sticky_ovf, sticky_unf;
    logic [CW-1:0]        sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dfe_stage_monitor #(
        .DATA_WIDTH(DW), .NUM_STAGES(NS), .CAP_DEPTH(CD), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .stage_data(stage_data), .stage_valid(stage_valid),
        .stage_ovf(stage_ovf), .stage_unf(stage_unf),
        .cfg_sel(cfg_sel), .arm(arm), .sticky_clr(sticky_clr), .rd_en(rd_en),
        .mon_out(mon_out), .mon_valid(mon_valid),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .sample_cnt(sample_cnt),
        .cap_busy(cap_busy), .cap_done(cap_done),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    typedef struct {
        logic [2:0]    sel;
        logic [NS-1:0] vld;
        logic [DW-1:0] d;
        logic [NS-1:0] ovf;
        logic          clr;
        logic [DW-1:0] e_out;
        logic          e_vld;
        logic [CW-1:0] e_cnt;
        logic [NS-1:0] e_sov;
    } vec_t;

    // Reference model state: captured samples live in a plain queue.
    logic [DW-1:0] e_mon_out, e_rd_data;
    logic          e_mon_valid, e_rd_valid;
    logic [NS-1:0] e_sov, e_sun;
    int            e_cnt, prev_sel, rd_idx;
    bit            capturing, done;
    logic [DW-1:0] cap_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stage_valid = '0;
        stage_ovf   = '0;
        stage_unf   = '0;
        arm         = 1'b0;
        sticky_clr  = 1'b0;
        rd_en       = 1'b0;
    endtask

    task automatic model_reset();
        e_mon_out = '0; e_mon_valid = 1'b0; e_rd_data = '0; e_rd_valid = 1'b0;
        e_sov = '0; e_sun = '0; e_cnt = 0; prev_sel = 0; rd_idx = 0;
        capturing = 1'b0; done = 1'b0;
        cap_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int  sel;
        bit  ok, v, chg;
        logic [DW-1:0] d;
        sel = int'(cfg_sel);
        ok  = (sel < NS);
        v   = ok && stage_valid[sel];
        d   = ok ? stage_data[sel] : '0;
        chg = (sel != prev_sel);
        e_mon_valid = v;
        if (!ok) e_mon_out = '0;
        else if (v) e_mon_out = d;
        e_sov = (e_sov & ~{NS{sticky_clr}}) | stage_ovf;
        e_sun = (e_sun & ~{NS{sticky_clr}}) | stage_unf;
        if (chg) e_cnt = 0;
        else if (v && e_cnt < (2**CW - 1)) e_cnt++;
        e_rd_valid = 1'b0;
        if (capturing) begin
            if (chg) begin
                capturing = 1'b0;
                cap_q.delete();
            end else if (v) begin
                cap_q.push_back(d);
                if (cap_q.size() == CD) begin
                    capturing = 1'b0;
                    done      = 1'b1;
                end
            end
        end else if (arm) begin
            capturing = 1'b1;
            done      = 1'b0;
            rd_idx    = 0;
            cap_q.delete();
        end else if (done && rd_en) begin
            e_rd_valid = 1'b1;
            e_rd_data  = cap_q[rd_idx];
            rd_idx     = (rd_idx + 1) % CD;
        end
        prev_sel = sel;
    endtask

    task automatic check_all();
        chk("mon_out",    32'(mon_out),    32'(e_mon_out));
        chk("mon_valid",  32'(mon_valid),  32'(e_mon_valid));
        chk("sticky_ovf", 32'(sticky_ovf), 32'(e_sov));
        chk("sticky_unf", 32'(sticky_unf), 32'(e_sun));
        chk("sample_cnt", 32'(sample_cnt), 32'(e_cnt));
        chk("cap_busy",   32'(cap_busy),   32'(capturing));
        chk("cap_done",   32'(cap_done),   32'(done));
        chk("rd_valid",   32'(rd_valid),   32'(e_rd_valid));
        chk("rd_data",    32'(rd_data),    32'(e_rd_data));
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3'd2, 6'b000100, 16'd1, 6'b000000, 1'b0, 16'd1, 1'b1, 4'd1, 6'b000000};
        tbl[1] = '{3'd2, 6'b000100, 16'd2, 6'b000000, 1'b0, 16'd2, 1'b1, 4'd2, 6'b000000};
        tbl[2] = '{3'd2, 6'b000100, 16'd3, 6'b000000, 1'b0, 16'd3, 1'b1, 4'd3, 6'b000000};
        tbl[3] = '{3'd2, 6'b000000, 16'd9, 6'b010000, 1'b0, 16'd3, 1'b0, 4'd3, 6'b010000};
        tbl[4] = '{3'd2, 6'b000000, 16'd0, 6'b010000, 1'b1, 16'd3, 1'b0, 4'd3, 6'b010000};
        tbl[5] = '{3'd2, 6'b000000, 16'd0, 6'b000000, 1'b1, 16'd3, 1'b0, 4'd3, 6'b000000};
        tbl[6] = '{3'd7, 6'b000100, 16'd5, 6'b000000, 1'b0, 16'd0, 1'b0, 4'd0, 6'b000000};
        tbl[7] = '{3'd7, 6'b000100, 16'd6, 6'b000000, 1'b0, 16'd0, 1'b0, 4'd0, 6'b000000};

        idle_inputs();
        cfg_sel = 3'd0;
        for (int i = 0; i < NS; i++) stage_data[i] = 16'h7777;

        // Reset values
        #12;
        chk("rst mon_out",    32'(mon_out),    0);
        chk("rst mon_valid",  32'(mon_valid),  0);
        chk("rst sticky_ovf", 32'(sticky_ovf), 0);
        chk("rst sample_cnt", 32'(sample_cnt), 0);
        chk("rst cap_busy",   32'(cap_busy),   0);
        chk("rst cap_done",   32'(cap_done),   0);
        chk("rst rd_valid",   32'(rd_valid),   0);
        #10 rst_n = 1'b1;

        // Tap, counter and sticky flag table
        cfg_sel = 3'd2;
        tick();
        for (int i = 0; i < 8; i++) begin
            cfg_sel       = tbl[i].sel;
            stage_valid   = tbl[i].vld;
            stage_data[2] = tbl[i].d;
            stage_ovf     = tbl[i].ovf;
            sticky_clr    = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d mon_out", i),    32'(mon_out),    32'(tbl[i].e_out));
            chk($sformatf("tbl%0d mon_valid", i),  32'(mon_valid),  32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d sample_cnt", i), 32'(sample_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d sticky_ovf", i), 32'(sticky_ovf), 32'(tbl[i].e_sov));
        end
        idle_inputs();

        // Full capture with random gaps, then readback with wrap
        cfg_sel = 3'd3;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm cap_busy", 32'(cap_busy), 1);
        chk("arm cap_done", 32'(cap_done), 0);
        for (int k = 0; k < CD; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                stage_valid   = 6'b110111;
                stage_data[0] = 16'($urandom);
                tick();
            end
            stage_valid   = 6'b001000;
            stage_data[3] = 16'(100 + k);
            tick();
            stage_valid   = '0;
            if (k == CD - 2) chk("cap busy before last", 32'(cap_busy), 1);
        end
        chk("cap_done after 32", 32'(cap_done), 1);
        chk("cap_busy after 32", 32'(cap_busy), 0);
        for (int r = 0; r <= CD; r++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("rd%0d valid", r), 32'(rd_valid), 1);
            chk($sformatf("rd%0d data", r),  32'(rd_data),  32'(100 + (r % CD)));
        end
        rd_en = 1'b1;
        arm   = 1'b1;
        tick();
        idle_inputs();
        chk("rd+arm rd_valid", 32'(rd_valid), 0);
        chk("rd+arm rd_data",  32'(rd_data),  100);
        chk("rd+arm cap_busy", 32'(cap_busy), 1);

        // Abort by selector change after 10 samples
        for (int k = 0; k < 10; k++) begin
            stage_valid   = 6'b001000;
            stage_data[3] = 16'(200 + k);
            tick();
        end
        stage_valid = '0;
        cfg_sel     = 3'd0;
        tick();
        chk("abort cap_busy", 32'(cap_busy), 0);
        chk("abort cap_done", 32'(cap_done), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("abort rd_valid", 32'(rd_valid), 0);
        chk("abort rd_data",  32'(rd_data),  100);

        // Counter saturation and clear on selector change
        cfg_sel = 3'd1;
        tick();
        for (int k = 0; k < 20; k++) begin
            stage_valid = 6'b000010;
            tick();
            if (k == 13) chk("cnt 14", 32'(sample_cnt), 14);
        end
        chk("cnt saturated", 32'(sample_cnt), 15);
        stage_valid = '0;
        cfg_sel     = 3'd5;
        tick();
        chk("cnt cleared", 32'(sample_cnt), 0);

        // Asynchronous reset in the middle of a capture
        stage_ovf = 6'b100001;
        tick();
        stage_ovf = '0;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stage_valid   = 6'b100000;
            stage_data[5] = 16'(300 + k);
            tick();
        end
        chk("pre-rst cap_busy",   32'(cap_busy),   1);
        chk("pre-rst mon_valid",  32'(mon_valid),  1);
        chk("pre-rst sticky_ovf", 32'(sticky_ovf), 32'h21);
        #3 rst_n = 1'b0;
        #1;
        chk("mid-rst cap_busy",   32'(cap_busy),   0);
        chk("mid-rst cap_done",   32'(cap_done),   0);
        chk("mid-rst sticky_ovf", 32'(sticky_ovf), 0);
        chk("mid-rst mon_valid",  32'(mon_valid),  0);
        chk("mid-rst mon_out",    32'(mon_out),    0);
        chk("mid-rst sample_cnt", 32'(sample_cnt), 0);
        idle_inputs();
        #2 rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 149) == 0) cfg_sel = 3'($urandom_range(0, 7));
            for (int i = 0; i < NS; i++) stage_data[i] = 16'($urandom);
            stage_valid = 6'($urandom | $urandom);
            stage_ovf   = 6'($urandom & $urandom & $urandom);
            stage_unf   = 6'($urandom & $urandom & $urandom);
            sticky_clr  = ($urandom_range(0, 7) == 0);
            arm         = ($urandom_range(0, 29) == 0);
            rd_en       = ($urandom_range(0, 2) == 0);
            model_step();
            tick();
            check_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
